// File: rtl/ddr4_phy_v2_2_1_pll_ctrl.sv
// ddr4_phy_v2_2_1_pll_ctrl: PHY PLL bank reset/lock sequencer with timeout retry and lock-loss supervision
module ddr4_phy_v2_2_1_pll_ctrl #(
  parameter int PLL_WIDTH    = 1,
  parameter int RST_HOLD_CYC = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int GATE_DELAY   = 8,
  parameter int MAX_RETRY    = 3,
  parameter int TCQ          = 100
) (
  input  logic                           div_clk,
  input  logic                           div_clk_rst,
  input  logic                           mmcm_lock,
  input  logic                           ub_rst_out,
  input  logic [PLL_WIDTH-1:0]           pll_lock_in,
  output logic                           pll_rst,
  output logic                           pllgate,
  output logic                           phy_clk_ready,
  output logic                           pll_fail,
  output logic                           lock_lost,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
  output logic [7:0]                     lost_cnt
);
  localparam int TMAX = RST_HOLD_CYC > LOCK_TIMEOUT ? RST_HOLD_CYC : LOCK_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int SW   = $clog2(GATE_DELAY + 1);
  localparam int RW   = $clog2(MAX_RETRY + 1);
  typedef enum logic [2:0] {IDLE, RST, WAIT_LOCK, DONE, FAIL} state_t;
  if (RST_HOLD_CYC < 2 || GATE_DELAY < 1 || MAX_RETRY < 1 || TCQ < 0) begin : g_param_check
    $error("ddr4_phy_v2_2_1_pll_ctrl: illegal parameter value");
  end
  state_t               state, state_nx;
  logic [TW-1:0]        timer, timer_nx;
  logic [SW-1:0]        stable, stable_nx;
  logic [RW-1:0]        retry_nx;
  logic [7:0]           lost_nx;
  logic [PLL_WIDTH-1:0] sync1, sync2;
  logic                 abort, lock_all, hold_end, tmo, gate_ok, loss;
  logic                 rst_nx, gate_nx, fail_nx;
  assign abort    = ~mmcm_lock | ub_rst_out;
  assign lock_all = &sync2;
  assign hold_end = timer == TW'(RST_HOLD_CYC - 1);
  assign tmo      = timer == TW'(LOCK_TIMEOUT - 1);
  // completes on the edge where the stable count would reach GATE_DELAY
  assign gate_ok  = lock_all && stable == SW'(GATE_DELAY - 1);
  always_ff @(posedge div_clk or posedge div_clk_rst)
    if (div_clk_rst) begin
      sync1         <= '0;
      sync2         <= '0;
      state         <= IDLE;
      timer         <= '0;
      stable        <= '0;
      retry_cnt     <= '0;
      lost_cnt      <= '0;
      pll_rst       <= 1'b1;
      pllgate       <= 1'b0;
      phy_clk_ready <= 1'b0;
      pll_fail      <= 1'b0;
      lock_lost     <= 1'b0;
    end else begin
      sync1         <= pll_lock_in;
      sync2         <= sync1;
      state         <= state_nx;
      timer         <= timer_nx;
      stable        <= stable_nx;
      retry_cnt     <= retry_nx;
      lost_cnt      <= lost_nx;
      pll_rst       <= rst_nx;
      pllgate       <= gate_nx;
      phy_clk_ready <= gate_nx;
      pll_fail      <= fail_nx;
      lock_lost     <= loss;
    end
  always_comb begin
    state_nx = state;
    retry_nx = retry_cnt;
    lost_nx  = lost_cnt;
    loss     = 1'b0;
    case (state)
      IDLE:      state_nx = abort ? IDLE : RST;
      RST:       state_nx = abort ? IDLE : hold_end ? WAIT_LOCK : RST;
      WAIT_LOCK:
        if (abort) state_nx = IDLE;
        else if (gate_ok) begin
          state_nx = DONE;
          retry_nx = '0;
        end else if (tmo) begin
          state_nx = retry_cnt == RW'(MAX_RETRY) ? FAIL : RST;
          retry_nx = retry_cnt == RW'(MAX_RETRY) ? retry_cnt : retry_cnt + RW'(1);
        end
      DONE:
        if (abort) state_nx = IDLE;
        else if (!lock_all) begin
          state_nx = RST;
          loss     = 1'b1;
          lost_nx  = &lost_cnt ? lost_cnt : lost_cnt + 8'd1;
        end
      default:   state_nx = FAIL;
    endcase
    timer_nx  = (state_nx == state && (state == RST || state == WAIT_LOCK)) ? timer + TW'(1) : '0;
    stable_nx = (state == WAIT_LOCK && state_nx == WAIT_LOCK && lock_all) ? stable + SW'(1) : '0;
  end
  always_comb begin
    rst_nx  = !(state_nx == WAIT_LOCK || state_nx == DONE);
    gate_nx = state_nx == DONE;
    fail_nx = state_nx == FAIL;
  end
endmodule

// File: tb/tb_ddr4_phy_v2_2_1_pll_ctrl.sv
// tb_ddr4_phy_v2_2_1_pll_ctrl: directed bench for the PLL bring-up sequencer at default parameters
module tb_ddr4_phy_v2_2_1_pll_ctrl;
  logic       clk = 1'b0, rst = 1'b1, mmcm_lock = 1'b1, ub_rst_out = 1'b0;
  logic [0:0] lock_in = 1'b0;
  logic       pll_rst, pllgate, phy_clk_ready, pll_fail, lock_lost;
  logic [1:0] retry_cnt;
  logic [7:0] lost_cnt;
  int         checks = 0, failures = 0, pulses = 0, n;
  ddr4_phy_v2_2_1_pll_ctrl dut (
    .div_clk(clk), .div_clk_rst(rst), .mmcm_lock(mmcm_lock), .ub_rst_out(ub_rst_out),
    .pll_lock_in(lock_in), .pll_rst(pll_rst), .pllgate(pllgate), .phy_clk_ready(phy_clk_ready),
    .pll_fail(pll_fail), .lock_lost(lock_lost), .retry_cnt(retry_cnt), .lost_cnt(lost_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (lock_lost === 1'b1) pulses++;
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // waits (bounded) for pll_rst high, then counts the negedges it stays high
  task automatic pulse_len(output int len);
    int w = 0;
    len = 0;
    while (pll_rst !== 1'b1 && w < 5000) begin tick(1); w++; end
    while (pll_rst === 1'b1 && len < 100) begin len++; tick(1); end
  endtask
  task automatic lose_once();
    int w = 0;
    lock_in = 1'b0;
    tick(1);
    lock_in = 1'b1;
    tick(2);
    while (pllgate !== 1'b1 && w < 100) begin tick(1); w++; end
  endtask
  initial begin
    tick(3);
    chk("reset_pll_rst", pll_rst, 1);
    chk("reset_gate", {pllgate, phy_clk_ready, pll_fail, lock_lost}, 0);
    chk("reset_cnts", {retry_cnt, lost_cnt}, 0);
    // bring-up: 16-cycle reset pulse, lock 5 cycles later, gate 10 cycles after lock
    rst = 1'b0;
    tick(1);
    pulse_len(n);
    chk("t1_rst_len", n, 16);
    tick(4);
    lock_in = 1'b1;
    tick(9);
    chk("t1_gate_early", pllgate, 0);
    tick(1);
    chk("t1_gate", {pllgate, phy_clk_ready, pll_rst}, 3'b110);
    chk("t1_retry", retry_cnt, 0);
    // single-cycle lock drop in DONE
    lock_in = 1'b0;
    tick(1);
    lock_in = 1'b1;
    tick(2);
    chk("t3_loss", {lock_lost, pllgate, phy_clk_ready, pll_rst}, 4'b1001);
    chk("t3_lost_cnt", lost_cnt, 1);
    pulse_len(n);
    chk("t3_rst_len", n, 16);
    tick(7);
    chk("t3_regate_early", pllgate, 0);
    tick(1);
    chk("t3_regate", pllgate, 1);
    chk("t3_pulses", pulses, 1);
    // lock glitch at stable=5 restarts the stable count
    lock_in = 1'b0;
    pulse_len(n);
    chk("t4_rst_len", n, 16);
    lock_in = 1'b1;
    tick(5);
    lock_in = 1'b0;
    tick(1);
    lock_in = 1'b1;
    tick(4);
    chk("t4_no_early_gate", pllgate, 0);
    tick(5);
    chk("t4_gate_m1", pllgate, 0);
    tick(1);
    chk("t4_gate", pllgate, 1);
    chk("t4_lost_cnt", lost_cnt, 2);
    // abort in DONE, then in WAIT_LOCK
    mmcm_lock = 1'b0;
    tick(1);
    chk("t5_done_abort", {pll_rst, pllgate, phy_clk_ready, lock_lost}, 4'b1000);
    mmcm_lock = 1'b1;
    tick(1);
    pulse_len(n);
    chk("t5_rst_len", n, 16);
    tick(3);
    mmcm_lock = 1'b0;
    tick(1);
    chk("t5_wait_abort", {pll_rst, pllgate}, 2'b10);
    mmcm_lock = 1'b1;
    tick(1);
    pulse_len(n);
    chk("t5_rst_len2", n, 16);
    tick(7);
    chk("t5_gate_early", pllgate, 0);
    tick(1);
    chk("t5_gate", pllgate, 1);
    ub_rst_out = 1'b1;
    tick(1);
    chk("t5_ub_abort", {pll_rst, pllgate}, 2'b10);
    ub_rst_out = 1'b0;
    chk("t5_no_pulse", pulses, 2);
    chk("t5_lost_cnt", lost_cnt, 2);
    tick(1);
    pulse_len(n);
    tick(8);
    chk("t5_ub_regate", pllgate, 1);
    // lost_cnt saturation
    for (int i = 0; i < 252; i++) lose_once();
    chk("t6_lost_254", lost_cnt, 254);
    lose_once();
    chk("t6_lost_255", lost_cnt, 255);
    lose_once();
    chk("t6_lost_sat", lost_cnt, 255);
    chk("t6_pulses", pulses, 256);
    // async reset mid-RST
    lock_in = 1'b0;
    tick(1);
    lock_in = 1'b1;
    tick(7);
    #2 rst = 1'b1;
    #1 chk("t6_async_rst", {pll_rst, pllgate, phy_clk_ready, pll_fail, lock_lost}, 5'b10000);
    chk("t6_async_cnts", {retry_cnt, lost_cnt}, 0);
    tick(2);
    // lock never arrives: 4 pulses, retries 1..3, then FAIL
    lock_in = 1'b0;
    rst = 1'b0;
    tick(1);
    pulse_len(n);
    chk("t2_first_len", n, 16);
    for (int k = 1; k <= 3; k++) begin
      pulse_len(n);
      chk("t2_retry_len", n, 16);
      chk("t2_retry_cnt", retry_cnt, k);
    end
    tick(4095);
    chk("t2_pre_fail", {pll_fail, pll_rst}, 2'b00);
    tick(1);
    chk("t2_fail", {pll_fail, pll_rst, pllgate, phy_clk_ready}, 4'b1100);
    chk("t2_fail_retry", retry_cnt, 3);
    mmcm_lock = 1'b0;
    tick(3);
    mmcm_lock = 1'b1;
    lock_in = 1'b1;
    tick(30);
    chk("t2_fail_sticky", {pll_fail, pll_rst, pllgate}, 3'b110);
    #2 rst = 1'b1;
    #1 chk("t2_fail_clear", {pll_fail, pll_rst, retry_cnt}, 4'b0100);
    tick(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
